// File: rtl/ldpc_decode_ctrl.sv
// Sequencing controller for the LDPC (15,8) receive path: detect, iteratively flip
// and re-check one word at a time, then hand off info bits with status and statistics.
module ldpc_decode_ctrl #(
  parameter int N        = 15,
  parameter int K        = 8,
  parameter int SYN_W    = 15,
  parameter int MAX_ITER = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_word,
  output logic [N-1:0]     det_c,
  input  logic [SYN_W-1:0] det_s,
  input  logic             det_error,
  output logic [SYN_W-1:0] corr_s,
  input  logic [N-1:0]     corr_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic             out_ok,
  output logic [3:0]       out_iter,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_failed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FLIP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]       MAX_ITER_C = 4'(MAX_ITER);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [N-1:0]     word_q, word_d;
  logic [SYN_W-1:0] syn_q, syn_d;
  logic [3:0]       iter_q, iter_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] cnt_words_q, cnt_words_d;
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_fail_q, cnt_fail_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state, datapath and statistics update.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    syn_d       = syn_q;
    iter_d      = iter_q;
    ok_d        = ok_q;
    cnt_words_d = cnt_words_q;
    cnt_corr_d  = cnt_corr_q;
    cnt_fail_d  = cnt_fail_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          iter_d  = 4'd0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (!det_error) begin
          ok_d    = 1'b1;
          state_d = DONE;
        end else if (iter_q == MAX_ITER_C) begin
          ok_d    = 1'b0;
          state_d = DONE;
        end else begin
          syn_d   = det_s;
          state_d = FLIP;
        end
      end
      FLIP: begin
        // An empty mask means the corrector has nothing to offer: give up now.
        if (corr_mask == {N{1'b0}}) begin
          ok_d    = 1'b0;
          state_d = DONE;
        end else begin
          word_d  = word_q ^ corr_mask;
          iter_d  = iter_q + 4'd1;
          state_d = CHECK;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_words_d = sat_inc(cnt_words_q);
          if (ok_q && (iter_q != 4'd0)) begin
            cnt_corr_d = sat_inc(cnt_corr_q);
          end else begin
            cnt_corr_d = cnt_corr_q;
          end
          if (!ok_q) begin
            cnt_fail_d = sat_inc(cnt_fail_q);
          end else begin
            cnt_fail_d = cnt_fail_q;
          end
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= {N{1'b0}};
      syn_q       <= {SYN_W{1'b0}};
      iter_q      <= 4'd0;
      ok_q        <= 1'b0;
      cnt_words_q <= {CNT_W{1'b0}};
      cnt_corr_q  <= {CNT_W{1'b0}};
      cnt_fail_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      syn_q       <= syn_d;
      iter_q      <= iter_d;
      ok_q        <= ok_d;
      cnt_words_q <= cnt_words_d;
      cnt_corr_q  <= cnt_corr_d;
      cnt_fail_q  <= cnt_fail_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign det_c         = word_q;
  assign corr_s        = syn_q;
  assign out_data      = word_q[K-1:0];
  assign out_iter      = iter_q;
  assign out_ok        = ok_q;
  assign cnt_words     = cnt_words_q;
  assign cnt_corrected = cnt_corr_q;
  assign cnt_failed    = cnt_fail_q;

endmodule

// File: tb/tb_ldpc_decode_ctrl.sv
// Directed bench for ldpc_decode_ctrl with a reference-word detector and a
// lowest-set-bit corrector model, plus forced modes for failure paths.
module tb_ldpc_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_word;
  logic [14:0] det_c;
  logic [14:0] det_s;
  logic        det_error;
  logic [14:0] corr_s;
  logic [14:0] corr_mask;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_ok;
  logic [3:0]  out_iter;
  logic [15:0] cnt_words;
  logic [15:0] cnt_corrected;
  logic [15:0] cnt_failed;

  logic [14:0] tx_ref;
  logic        force_err;
  logic [1:0]  mask_mode;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  ldpc_decode_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .det_c(det_c), .det_s(det_s), .det_error(det_error),
    .corr_s(corr_s), .corr_mask(corr_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ok(out_ok), .out_iter(out_iter),
    .cnt_words(cnt_words), .cnt_corrected(cnt_corrected), .cnt_failed(cnt_failed)
  );

  // Detector/corrector models: syndrome is the difference from the transmitted word.
  always_comb begin
    det_s     = det_c ^ tx_ref;
    det_error = force_err ? 1'b1 : (det_s != 15'd0);
    case (mask_mode)
      2'd1:    corr_mask = 15'd0;
      2'd2:    corr_mask = 15'h0001;
      default: corr_mask = corr_s & (~corr_s + 15'd1);
    endcase
  end

  function automatic logic [14:0] encode(input logic [7:0] d);
    encode = {d[7:1] ^ d[6:0], d};
  endfunction

  // Presents one word in IDLE, then counts cycles until out_valid (bounded at 40).
  task automatic send_and_wait(input logic [14:0] w, output int cyc);
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_ok, out_data, out_iter} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b ok=%b data=%h iter=%0d required 1 0 0 00 0",
               in_ready, out_valid, out_ok, out_data, out_iter);
    end
    checks++;
    if ({cnt_words, cnt_corrected, cnt_failed, det_c, corr_s} !== {16'd0, 16'd0, 16'd0, 15'd0, 15'd0}) begin
      failures++;
      $display("FAIL reset_state: got words=%0d corr=%0d fail=%0d det_c=%h corr_s=%h required all 0",
               cnt_words, cnt_corrected, cnt_failed, det_c, corr_s);
    end
  endtask

  task automatic test_clean;
    int cyc;
    tx_ref = encode(8'hA5);
    send_and_wait(tx_ref, cyc);
    checks++;
    if ({cyc, out_data, out_ok, out_iter} !== {32'd2, 8'hA5, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL clean_result: got lat=%0d data=%h ok=%b iter=%0d required 2 a5 1 0",
               cyc, out_data, out_ok, out_iter);
    end
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, cnt_words, cnt_corrected, cnt_failed} !== {1'b1, 1'b0, 16'd1, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL clean_counters: got rdy=%b vld=%b words=%0d corr=%0d fail=%0d required 1 0 1 0 0",
               in_ready, out_valid, cnt_words, cnt_corrected, cnt_failed);
    end
  endtask

  task automatic test_single_flip;
    int cyc;
    tx_ref = encode(8'h3C);
    send_and_wait(tx_ref ^ 15'h0001, cyc);
    checks++;
    if ({cyc, out_data, out_ok, out_iter} !== {32'd4, 8'h3C, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL flip_result: got lat=%0d data=%h ok=%b iter=%0d required 4 3c 1 1",
               cyc, out_data, out_ok, out_iter);
    end
    @(posedge clk); #1;
    checks++;
    if ({cnt_words, cnt_corrected, cnt_failed} !== {16'd2, 16'd1, 16'd0}) begin
      failures++;
      $display("FAIL flip_counters: got words=%0d corr=%0d fail=%0d required 2 1 0",
               cnt_words, cnt_corrected, cnt_failed);
    end
  endtask

  task automatic test_stuck;
    int cyc;
    tx_ref    = encode(8'h77);
    mask_mode = 2'd1;
    send_and_wait(tx_ref ^ 15'h0100, cyc);
    checks++;
    if ({cyc, out_data, out_ok, out_iter} !== {32'd3, 8'h77, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL stuck_result: got lat=%0d data=%h ok=%b iter=%0d required 3 77 0 0",
               cyc, out_data, out_ok, out_iter);
    end
    @(posedge clk); #1;
    mask_mode = 2'd0;
    checks++;
    if ({cnt_words, cnt_corrected, cnt_failed} !== {16'd3, 16'd1, 16'd1}) begin
      failures++;
      $display("FAIL stuck_counters: got words=%0d corr=%0d fail=%0d required 3 1 1",
               cnt_words, cnt_corrected, cnt_failed);
    end
  endtask

  task automatic test_max_iter;
    int cyc;
    tx_ref    = encode(8'h5A);
    force_err = 1'b1;
    mask_mode = 2'd2;
    send_and_wait(tx_ref, cyc);
    checks++;
    if ({cyc, out_data, out_ok, out_iter} !== {32'd10, 8'h5A, 1'b0, 4'd4}) begin
      failures++;
      $display("FAIL maxiter_result: got lat=%0d data=%h ok=%b iter=%0d required 10 5a 0 4",
               cyc, out_data, out_ok, out_iter);
    end
    @(posedge clk); #1;
    force_err = 1'b0;
    mask_mode = 2'd0;
    checks++;
    if ({cnt_words, cnt_corrected, cnt_failed} !== {16'd4, 16'd1, 16'd2}) begin
      failures++;
      $display("FAIL maxiter_counters: got words=%0d corr=%0d fail=%0d required 4 1 2",
               cnt_words, cnt_corrected, cnt_failed);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    tx_ref    = encode(8'hC3);
    send_and_wait(tx_ref, cyc);
    checks++;
    if ({cyc, out_data, out_ok} !== {32'd2, 8'hC3, 1'b1}) begin
      failures++;
      $display("FAIL bp_first: got lat=%0d data=%h ok=%b required 2 c3 1", cyc, out_data, out_ok);
    end
    in_valid = 1'b1;
    in_word  = encode(8'h11);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, out_data, out_ok, out_iter, det_c} !==
          {1'b1, 1'b0, 8'hC3, 1'b1, 4'd0, tx_ref}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b data=%h ok=%b iter=%0d det_c=%h required 1 0 c3 1 0 %h",
                 i, out_valid, in_ready, out_data, out_ok, out_iter, det_c, tx_ref);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, cnt_words, cnt_failed} !== {1'b0, 1'b1, 16'd5, 16'd2}) begin
      failures++;
      $display("FAIL bp_release: got vld=%b rdy=%b words=%0d fail=%0d required 0 1 5 2",
               out_valid, in_ready, cnt_words, cnt_failed);
    end
  endtask

  task automatic test_reset_in_flip;
    int cyc;
    tx_ref   = encode(8'h96);
    in_valid = 1'b1;
    in_word  = tx_ref ^ 15'h0004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, corr_s} !== {1'b0, 1'b0, 15'h0004}) begin
      failures++;
      $display("FAIL flip_entry: got rdy=%b vld=%b corr_s=%h required 0 0 0004", in_ready, out_valid, corr_s);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, cnt_words, cnt_corrected, cnt_failed, det_c} !==
        {1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 15'd0}) begin
      failures++;
      $display("FAIL rst_flip: got rdy=%b vld=%b words=%0d corr=%0d fail=%0d det_c=%h required 1 0 0 0 0 0000",
               in_ready, out_valid, cnt_words, cnt_corrected, cnt_failed, det_c);
    end
    tx_ref = encode(8'h00);
    send_and_wait(tx_ref, cyc);
    checks++;
    if ({cyc, out_data, out_ok, out_iter} !== {32'd2, 8'h00, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL post_rst_result: got lat=%0d data=%h ok=%b iter=%0d required 2 00 1 0",
               cyc, out_data, out_ok, out_iter);
    end
    @(posedge clk); #1;
    checks++;
    if ({cnt_words, cnt_corrected, cnt_failed} !== {16'd1, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL post_rst_counters: got words=%0d corr=%0d fail=%0d required 1 0 0",
               cnt_words, cnt_corrected, cnt_failed);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = 15'd0;
    out_ready = 1'b1;
    tx_ref    = 15'd0;
    force_err = 1'b0;
    mask_mode = 2'd0;
    test_reset();
    test_clean();
    test_single_flip();
    test_stuck();
    test_max_iter();
    test_backpressure();
    test_reset_in_flip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ldpc_decode_ctrl.md
Name: ldpc_decode_ctrl

Overview:
- Sequencing controller for the LDPC (15,8) receive path.
- Accepts received 15-bit codewords over a valid/ready handshake and drives the shared combinational detector (codeword to syndrome and error flag).
- On a nonzero syndrome, drives the shared corrector (syndrome to flip mask), applies the mask and re-checks, repeating up to MAX_ITER times.
- Emits the 8 information bits with status, and keeps saturating statistics counters.

Parameters:
- N, 15, codeword width.
- K, 8, information width; info bits occupy codeword bits [K-1:0].
- SYN_W, 15, detector syndrome width.
- MAX_ITER, 4, maximum flip iterations per word (1..15).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  received word valid
- in_ready  out  1  controller can accept a word
- in_word  in  N  received (channel) codeword
- det_c  out  N  word presented to detector
- det_s  in  SYN_W  detector syndrome (combinational from det_c)
- det_error  in  1  detector error flag (combinational from det_c)
- corr_s  out  SYN_W  syndrome presented to corrector
- corr_mask  in  N  corrector flip mask (combinational from corr_s)
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts result
- out_data  out  K  decoded info bits
- out_ok  out  1  1 = final syndrome clean, 0 = decode failure
- out_iter  out  4  flip iterations applied to this word
- cnt_words  out  CNT_W  words completed
- cnt_corrected  out  CNT_W  words completed ok with out_iter>0
- cnt_failed  out  CNT_W  words completed with out_ok=0

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; word_q, syn_q and iter cleared.
  - out_valid, out_ok, out_data, out_iter = 0; all counters = 0.
  - Takes priority over every other event; a word in flight is discarded silently, and counters do not increment for it.
- Registered outputs:
  - det_c = word_q at all times.
  - corr_s = syn_q at all times.
  - out_data = word_q[K-1:0]; out_iter = iter.
- FSM states: IDLE, CHECK, FLIP, DONE.
- IDLE:
  - in_ready=1, the only state with in_ready high.
  - On in_valid: word_q<=in_word, iter<=0, go to CHECK.
- CHECK (1 cycle), sampling det_error/det_s for the current word_q:
  - det_error=0: out_ok<=1, go to DONE.
  - det_error=1 and iter==MAX_ITER: out_ok<=0, go to DONE.
  - Otherwise: syn_q<=det_s, go to FLIP.
- FLIP (1 cycle), sampling corr_mask:
  - mask==0: out_ok<=0, iter unchanged, go to DONE (stuck).
  - Otherwise: word_q<=word_q^corr_mask, iter<=iter+1, go to CHECK.
- DONE:
  - out_valid=1; out_* held stable until out_ready=1.
  - On the out_valid&out_ready edge:
    - cnt_words+1.
    - cnt_corrected+1 if out_ok&&iter>0.
    - cnt_failed+1 if !out_ok.
    - Go to IDLE.
  - out_valid deasserts the following cycle.
- Latency:
  - Clean word accepted at edge T: CHECK in cycle T+1, out_valid first high in cycle T+2.
  - Each flip iteration adds 2 cycles.
  - Worst case is 2+2*MAX_ITER cycles to out_valid.
- Throughput:
  - One word in flight; no accept while busy.
  - Minimum spacing is 3 cycles (IDLE, CHECK, DONE with out_ready=1).
- Counters saturate at 2^CNT_W-1 and never wrap.
- in_word, det_* and corr_mask are ignored outside the states that sample them.
- Any X on det_error in CHECK is a bench error; it is not masked by the RTL.

Test Plan:
- Data 8'hA5 through generator, errors=0, out_ready=1 -> out_valid 2 cycles after accept, out_data=8'hA5, out_ok=1, out_iter=0; cnt_words=1, cnt_corrected=0.
- Data 8'h3C, errors=15'h0001 -> after one CHECK/FLIP/CHECK, out_data=8'h3C, out_ok=1, out_iter=1, out_valid 4 cycles after accept; cnt_corrected=1.
- Bench corrector model forced to mask=0 with a nonzero-syndrome word -> out_ok=0, out_iter=0, out_valid 3 cycles after accept; cnt_failed=1.
- Detector forced det_error=1 and corrector mask=15'h0001 constant, MAX_ITER=4 -> out_ok=0, out_iter=4, out_valid 10 cycles after accept.
- Backpressure: out_ready held low 5 cycles in DONE -> out_valid and out_* stable, in_ready=0 and new in_valid ignored; result consumed on the first out_ready=1, IDLE on the next cycle.
- Assert rst for 1 cycle while in FLIP -> next cycle IDLE, in_ready=1, out_valid=0, counters=0; a following clean word 8'h00 decodes normally.
